clk_div_counter: RTL and testbench
==================================

Name: clk_div_counter

Overview:
- Parametrised successor to the board's free-running LED counter.
- Adds a programmable prescaler, up/down counting, parallel load, and wrap or saturate mode.
- Adds a selectable bit window driven to LEDs/IO, plus a wrap pulse.
- Sits between board keys/control logic and the LED bank; also usable as a generic timebase.

Parameters:
- WIDTH, 29, counter width in bits (min 2).
- OUT_W, 8, display window width (OUT_W <= WIDTH).
- PRESCALE, 1, enabled clocks per count step (>= 1); 1 = step every enabled cycle.
- SATURATE, 0, 0 = wrap at ends, 1 = hold at max (up) or at 0 (down).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  count enable; low freezes counter and prescaler.
- DIR  input  1  1 = count up, 0 = count down.
- CLR  input  1  synchronous clear of counter and prescaler.
- LOAD  input  1  load LOAD_VAL into counter.
- LOAD_VAL  input  WIDTH  parallel load value.
- SHIFT  input  5  window low-bit index; OUT = COUNT[SHIFT+OUT_W-1:SHIFT].
- COUNT  output  WIDTH  current count (register).
- OUT  output  OUT_W  registered display window.
- TICK  output  1  prescaler step strobe (combinational from prescaler state and EN).
- WRAP  output  1  one-cycle pulse on wrap or saturation hit.

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high.
- Reset values: COUNT=0, prescaler=0, OUT=0, WRAP=0. TICK=0 while RST is high.
- Priority each cycle: RST > CLR > LOAD > count step.
- CLR: COUNT<=0, prescaler<=0, WRAP<=0. CLR ignores EN.
- LOAD: COUNT<=LOAD_VAL, prescaler<=0, WRAP<=0. LOAD ignores EN.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1; holds while EN=0.
  - TICK=1 when EN=1 and prescaler==PRESCALE-1; prescaler then returns to 0.
  - For PRESCALE=1, TICK=EN.
- Count step on TICK:
  - Up: COUNT+1. Down: COUNT-1. Arithmetic is modulo 2^WIDTH.
  - Wrap mode: up from all-ones gives 0 with WRAP<=1; down from 0 gives all-ones with WRAP<=1.
  - Saturate mode: at all-ones going up, or at 0 going down, COUNT holds and WRAP<=1 on every such TICK.
  - In all other cases WRAP<=0. WRAP is registered and coincides with the cycle the new COUNT appears.
- DIR is sampled only on TICK; it may change freely between ticks.
- OUT is registered: it reflects COUNT and SHIFT from the previous cycle (1-cycle latency behind COUNT).
- SHIFT out of range: window bits at index >= WIDTH read as 0 (zero-extended).
- Mid-count EN deassert: COUNT and prescaler phase are preserved; stepping resumes from the same phase.
- Simultaneous CLR+LOAD: CLR wins. LOAD with TICK: load wins and no step occurs.

Optional Feature:
- Macro: CLK_DIV_COUNTER_KEY_SYNC_EN.
- Defined:
  - EN, DIR, CLR and LOAD each pass through a 2-flop synchroniser (reset to 0) before use, adding 2 cycles of input latency.
  - LOAD_VAL is not synchronised; the caller holds it stable.
  - Use this when the inputs come from board keys; the active-low KEY inversion stays outside the block.
- Undefined: inputs are used directly, with zero added latency.

Decomposition:
- Package clk_div_counter_pkg holds:
  - DIR_UP=1 and DIR_DOWN=0 constants.
  - Constant function clog2 for sizing the prescaler (width clog2(PRESCALE), min 1).
  - Mode constants MODE_WRAP=0 and MODE_SAT=1.
- One sub-module, clk_tick_gen: prescaler with inputs CLK, RST, EN, CLR_PH and output TICK. CLR_PH is driven by CLR|LOAD.

Test Plan:
- RST=1 for 3 cycles with EN=1 -> COUNT=0, OUT=0, WRAP=0, TICK=0; after release with PRESCALE=1, DIR=1, COUNT=1,2,3 on consecutive cycles and OUT lags COUNT by 1 cycle.
- PRESCALE=4, EN=1, DIR=1 for 12 cycles -> TICK high every 4th cycle; COUNT=3; drop EN for 5 cycles -> COUNT and phase frozen, next TICK 4-phase-aligned after EN returns.
- WIDTH=4, wrap mode, LOAD_VAL=14, LOAD, then DIR=1 -> 14,15,0 with WRAP pulsed exactly on the 0 cycle; DIR=0 from 0 -> 15 with WRAP=1.
- SATURATE=1, WIDTH=4, at 15 going up for 3 ticks -> COUNT stays 15, WRAP=1 each tick; DIR=0 at 0 -> COUNT stays 0, WRAP=1.
- CLR and LOAD asserted together on a TICK cycle with COUNT=9 -> COUNT=0 next cycle, prescaler=0; LOAD alone on a TICK cycle with LOAD_VAL=5 -> COUNT=5, no step.
- WIDTH=29, OUT_W=8, SHIFT=21 -> OUT=COUNT[28:21]; SHIFT=25 -> OUT[7:4]=0, OUT[3:0]=COUNT[28:25]; with CLK_DIV_COUNTER_KEY_SYNC_EN defined, first step appears 2 cycles later than without.

Source files
------------

// File: rtl/clk_div_counter_pkg.sv
// Shared constants and helpers for the clk_div_counter block.
//   DIR_UP / DIR_DOWN   : encodings of the DIR input
//   MODE_WRAP / MODE_SAT: encodings of the SATURATE parameter
//   clog2()             : prescaler width helper, never returns less than 1
package clk_div_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Bits needed to hold 0..value-1; at least one so a PRESCALE of 1 still
  // yields a legal (constant-zero) phase register.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler for clk_div_counter: emits one TICK every PRESCALE enabled cycles.
// Ports:
//   CLK    : system clock
//   RST    : synchronous active-high reset (phase -> 0, TICK forced low)
//   EN     : advance the phase; low holds it
//   CLR_PH : synchronous phase clear (counter clear or load)
//   TICK   : combinational step strobe, high on the last phase while EN=1
module clk_tick_gen
  import clk_div_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR_PH,
  output logic TICK
);

  localparam int unsigned     PH_W    = clog2(PRESCALE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PRESCALE - 1);

  logic [PH_W-1:0] ph_q, ph_d;

  always_comb begin
    TICK = ~RST & EN & (ph_q == PH_LAST);
  end

  always_comb begin
    ph_d = ph_q;
    if (CLR_PH) begin
      ph_d = '0;
    end else if (EN) begin
      ph_d = TICK ? '0 : ph_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/clk_div_counter.sv
// Prescaled up/down counter with parallel load, wrap/saturate mode, a
// selectable registered bit window for LEDs, and a registered wrap pulse.
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   EN, DIR        : count enable, direction (1 = up)
//   CLR, LOAD      : synchronous clear / parallel load (both ignore EN)
//   LOAD_VAL       : load value
//   SHIFT          : window low-bit index for OUT
//   COUNT, OUT     : counter register, registered window COUNT[SHIFT +: OUT_W]
//   TICK, WRAP     : prescaler strobe, one-cycle wrap/saturation pulse
// Build option: define CLK_DIV_COUNTER_KEY_SYNC_EN to pass EN, DIR, CLR and
// LOAD through 2-flop synchronisers (for board keys). LOAD_VAL is not
// synchronised and must be held stable by the caller.
module clk_div_counter
  import clk_div_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 29,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [4:0]       SHIFT,
  output logic [WIDTH-1:0] COUNT,
  output logic [OUT_W-1:0] OUT,
  output logic             TICK,
  output logic             WRAP
);

  localparam logic             SAT_MODE = (SATURATE != MODE_WRAP);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic en_s, dir_s, clr_s, load_s;
  logic tick;
  logic [WIDTH-1:0] count_d;
  logic [OUT_W-1:0] out_d;
  logic             wrap_d;

`ifdef CLK_DIV_COUNTER_KEY_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {LOAD, CLR, DIR, EN};
      sync2_q <= sync1_q;
    end
  end

  assign {load_s, clr_s, dir_s, en_s} = sync2_q;
`else
  assign {load_s, clr_s, dir_s, en_s} = {LOAD, CLR, DIR, EN};
`endif

  clk_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (en_s),
    .CLR_PH(clr_s | load_s),
    .TICK  (tick)
  );

  assign TICK = tick;

  // Clear beats load beats step; a load on a tick cycle suppresses the step.
  always_comb begin
    count_d = COUNT;
    wrap_d  = 1'b0;
    if (clr_s) begin
      count_d = '0;
    end else if (load_s) begin
      count_d = LOAD_VAL;
    end else if (tick) begin
      case (dir_s)
        DIR_UP: begin
          if (COUNT == CNT_MAX) begin
            wrap_d  = 1'b1;
            count_d = SAT_MODE ? COUNT : '0;
          end else begin
            count_d = COUNT + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (COUNT == '0) begin
            wrap_d  = 1'b1;
            count_d = SAT_MODE ? COUNT : CNT_MAX;
          end else begin
            count_d = COUNT - 1'b1;
          end
        end
        default: count_d = COUNT;
      endcase
    end
  end

  // Window bits past the top of COUNT read as zero.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      int idx;
      idx = int'(SHIFT) + i;
      if (idx < int'(WIDTH)) out_d[i] = COUNT[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT <= '0;
      OUT   <= '0;
      WRAP  <= 1'b0;
    end else begin
      COUNT <= count_d;
      OUT   <= out_d;
      WRAP  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_clk_div_counter.sv
// Bench for clk_div_counter: four configurations share one stimulus stream
// and are compared every cycle against a behavioural model; a vector table
// and hand-written sequences pin down the directed corner cases.
module tb_clk_div_counter;

  localparam int N_INST = 4;
`ifdef CLK_DIV_COUNTER_KEY_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // Per-instance configuration: width, window width, prescale, saturate.
  int P_W   [N_INST] = '{29, 6, 4, 4};
  int P_OW  [N_INST] = '{8, 4, 4, 2};
  int P_PS  [N_INST] = '{1, 4, 1, 3};
  int P_SAT [N_INST] = '{0, 0, 1, 0};

  logic        CLK = 1'b0;
  logic        RST, EN, DIR, CLR, LOAD;
  logic [28:0] LOAD_VAL;
  logic [4:0]  SHIFT;

  logic [28:0] c0;  logic [7:0] o0;  logic t0, w0;
  logic [5:0]  c1;  logic [3:0] o1;  logic t1, w1;
  logic [3:0]  c2;  logic [3:0] o2;  logic t2, w2;
  logic [3:0]  c3;  logic [1:0] o3;  logic t3, w3;

  always #5 CLK = ~CLK;

  clk_div_counter #(.WIDTH(29), .OUT_W(8), .PRESCALE(1), .SATURATE(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SHIFT(SHIFT), .COUNT(c0), .OUT(o0), .TICK(t0), .WRAP(w0));
  clk_div_counter #(.WIDTH(6), .OUT_W(4), .PRESCALE(4), .SATURATE(0)) u_dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[5:0]), .SHIFT(SHIFT), .COUNT(c1), .OUT(o1), .TICK(t1), .WRAP(w1));
  clk_div_counter #(.WIDTH(4), .OUT_W(4), .PRESCALE(1), .SATURATE(1)) u_dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[3:0]), .SHIFT(SHIFT), .COUNT(c2), .OUT(o2), .TICK(t2), .WRAP(w2));
  clk_div_counter #(.WIDTH(4), .OUT_W(2), .PRESCALE(3), .SATURATE(0)) u_dut3 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[3:0]), .SHIFT(SHIFT), .COUNT(c3), .OUT(o3), .TICK(t3), .WRAP(w3));

  logic [63:0] a_cnt [N_INST];
  logic [63:0] a_out [N_INST];
  logic        a_wrap[N_INST];
  logic        a_tick[N_INST];

  always_comb begin
    a_cnt[0] = 64'(c0); a_out[0] = 64'(o0); a_wrap[0] = w0; a_tick[0] = t0;
    a_cnt[1] = 64'(c1); a_out[1] = 64'(o1); a_wrap[1] = w1; a_tick[1] = t1;
    a_cnt[2] = 64'(c2); a_out[2] = 64'(o2); a_wrap[2] = w2; a_tick[2] = t2;
    a_cnt[3] = 64'(c3); a_out[3] = 64'(o3); a_wrap[3] = w3; a_tick[3] = t3;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 0;
  bit last_tick[N_INST];

  // Model state: plain integers, arithmetic modulo 2**width done explicitly.
  longint m_cnt [N_INST];
  longint m_ph  [N_INST];
  longint m_out [N_INST];
  bit     m_wrap[N_INST];
  bit [3:0] sp1 = '0, sp2 = '0;  // {load, clr, dir, en} input delay line

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [3:0] eff();
    return (SYNC_LAT == 2) ? sp2 : {LOAD, CLR, DIR, EN};
  endfunction

  task automatic check_all();
    bit [3:0] e;
    bit       et;
    e = eff();
    for (int k = 0; k < N_INST; k++) begin
      et = !RST && e[0] && (m_ph[k] == longint'(P_PS[k] - 1));
      check($sformatf("count[%0d]", k), a_cnt[k], 64'(m_cnt[k]));
      check($sformatf("out[%0d]", k), a_out[k], 64'(m_out[k]));
      check($sformatf("wrap[%0d]", k), 64'(a_wrap[k]), 64'(m_wrap[k]));
      check($sformatf("tick[%0d]", k), 64'(a_tick[k]), 64'(et));
      last_tick[k] = a_tick[k];
    end
  endtask

  task automatic model_update();
    bit [3:0] e;
    e = eff();
    for (int k = 0; k < N_INST; k++) begin
      longint maxv;
      longint nxt;
      bit     t;
      maxv = (longint'(1) << P_W[k]) - 1;
      if (RST) begin
        m_cnt[k] = 0; m_ph[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
      end else begin
        m_out[k]  = (m_cnt[k] >> SHIFT) & ((longint'(1) << P_OW[k]) - 1);
        m_wrap[k] = 0;
        if (e[2]) begin
          m_cnt[k] = 0; m_ph[k] = 0;
        end else if (e[3]) begin
          m_cnt[k] = longint'(LOAD_VAL) & maxv; m_ph[k] = 0;
        end else begin
          t = e[0] && (m_ph[k] == longint'(P_PS[k] - 1));
          if (e[0]) m_ph[k] = t ? 0 : m_ph[k] + 1;
          if (t) begin
            nxt = e[1] ? m_cnt[k] + 1 : m_cnt[k] - 1;
            if (nxt > maxv || nxt < 0) begin
              m_wrap[k] = 1;
              m_cnt[k]  = (P_SAT[k] != 0) ? m_cnt[k] : (nxt & maxv);
            end else begin
              m_cnt[k] = nxt;
            end
          end
        end
      end
    end
    if (RST) begin
      sp1 = '0; sp2 = '0;
    end else begin
      sp2 = sp1; sp1 = {LOAD, CLR, DIR, EN};
    end
  endtask

  // Inputs are already driven; check pre-edge state, then advance the model.
  task automatic cycle();
    @(negedge CLK);
    if (armed) check_all();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  typedef struct {
    bit rst, en, dir, clr, load;
    int unsigned lv, shift;
    longint e_c0, e_o0;
    bit e_w0;
    longint e_c2;
    bit e_w2;
  } vec_t;

  localparam int NV = 19;
  localparam longint M29 = (longint'(1) << 29) - 1;
  vec_t tbl[NV];

  function automatic vec_t mk(bit rst, bit en, bit dir, bit clr, bit load, int unsigned lv,
                              int unsigned sh, longint ec0, longint eo0, bit ew0,
                              longint ec2, bit ew2);
    vec_t v;
    v.rst = rst; v.en = en; v.dir = dir; v.clr = clr; v.load = load; v.lv = lv;
    v.shift = sh; v.e_c0 = ec0; v.e_o0 = eo0; v.e_w0 = ew0; v.e_c2 = ec2; v.e_w2 = ew2;
    return v;
  endfunction

  initial begin
    int ticks;
    int first_tick;

    // Expected values are the post-edge state of instance 0 (29-bit wrap,
    // prescale 1) and instance 2 (4-bit saturating, prescale 1).
    tbl[0]  = mk(1, 1, 1, 0, 0,  0,  0, 0,       0,   0, 0,  0);
    tbl[1]  = mk(1, 1, 1, 0, 0,  0,  0, 0,       0,   0, 0,  0);
    tbl[2]  = mk(1, 1, 1, 0, 0,  0,  0, 0,       0,   0, 0,  0);
    tbl[3]  = mk(0, 1, 1, 0, 0,  0,  0, 1,       0,   0, 1,  0);
    tbl[4]  = mk(0, 1, 1, 0, 0,  0,  0, 2,       1,   0, 2,  0);
    tbl[5]  = mk(0, 1, 1, 0, 0,  0,  0, 3,       2,   0, 3,  0);
    tbl[6]  = mk(0, 1, 1, 0, 1, 14,  0, 14,      3,   0, 14, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 14,  0, 15,      14,  0, 15, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 14,  0, 16,      15,  0, 15, 1);
    tbl[9]  = mk(0, 1, 1, 0, 0, 14,  0, 17,      16,  0, 15, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 14,  0, 17,      17,  0, 15, 0);
    tbl[11] = mk(0, 1, 1, 0, 1,  0,  0, 0,       17,  0, 0,  0);
    tbl[12] = mk(0, 1, 0, 0, 0,  0,  0, M29,     0,   1, 0,  1);
    tbl[13] = mk(0, 1, 0, 0, 0,  0, 21, M29 - 1, 255, 0, 0,  1);
    tbl[14] = mk(0, 0, 0, 0, 0,  0, 25, M29 - 1, 15,  0, 0,  0);
    tbl[15] = mk(0, 1, 1, 0, 1,  9, 25, 9,       15,  0, 9,  0);
    tbl[16] = mk(0, 1, 1, 1, 1,  5,  0, 0,       9,   0, 0,  0);
    tbl[17] = mk(0, 1, 1, 0, 1,  5,  0, 5,       0,   0, 5,  0);
    tbl[18] = mk(0, 1, 1, 0, 0,  5,  0, 6,       5,   0, 6,  0);

    RST = 1; EN = 1; DIR = 1; CLR = 0; LOAD = 0; LOAD_VAL = '0; SHIFT = '0;
    cycle();
    armed = 1;

    // Vector table. Unsynchronised LOAD_VAL/SHIFT follow the synchronised
    // controls so every row's effect just lands SYNC_LAT cycles later.
    for (int r = 0; r < NV; r++) begin
      int src;
      src = (r >= SYNC_LAT) ? r - SYNC_LAT : 0;
      RST = tbl[r].rst; EN = tbl[r].en; DIR = tbl[r].dir;
      CLR = tbl[r].clr; LOAD = tbl[r].load;
      LOAD_VAL = 29'(tbl[src].lv); SHIFT = 5'(tbl[src].shift);
      cycle();
      if (r >= SYNC_LAT) begin
        check($sformatf("tbl%0d_count0", r), 64'(c0), 64'(tbl[src].e_c0));
        check($sformatf("tbl%0d_out0", r), 64'(o0), 64'(tbl[src].e_o0));
        check($sformatf("tbl%0d_wrap0", r), 64'(w0), 64'(tbl[src].e_w0));
        check($sformatf("tbl%0d_count2", r), 64'(c2), 64'(tbl[src].e_c2));
        check($sformatf("tbl%0d_wrap2", r), 64'(w2), 64'(tbl[src].e_w2));
      end
    end

    // Prescale-4 instance: 12 enabled cycles give 3 ticks, EN low freezes
    // count and phase, and the next tick stays on the 4-cycle grid.
    RST = 0; CLR = 1; LOAD = 0; EN = 0; DIR = 1; SHIFT = '0;
    for (int i = 0; i < 1 + SYNC_LAT; i++) cycle();
    CLR = 0;
    ticks = 0;
    for (int i = 0; i < 12 + SYNC_LAT; i++) begin
      EN = (i < 12);
      cycle();
      if (i >= SYNC_LAT) ticks += int'(last_tick[1]);
    end
    check("ps4_ticks_12cyc", 64'(ticks), 64'd3);
    check("ps4_count_12cyc", 64'(c1), 64'd3);
    EN = 0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      ticks += int'(last_tick[1]);
    end
    check("ps4_ticks_frozen", 64'(ticks), 64'd0);
    check("ps4_count_frozen", 64'(c1), 64'd3);
    EN = 1;
    first_tick = -1;
    for (int i = 0; i < SYNC_LAT + 5; i++) begin
      cycle();
      if (last_tick[1] && first_tick < 0) first_tick = i;
    end
    check("ps4_resume_phase", 64'(first_tick), 64'(SYNC_LAT + 3));

    // Randomised traffic against the model, biased towards the count ends.
    for (int i = 0; i < 3000; i++) begin
      RST  = ($urandom_range(199) == 0);
      EN   = ($urandom_range(3) != 0);
      CLR  = ($urandom_range(39) == 0);
      LOAD = ($urandom_range(29) == 0);
      if ($urandom_range(7) == 0) DIR = ~DIR;
      case ($urandom_range(3))
        0:       LOAD_VAL = '0;
        1:       LOAD_VAL = '1;
        2:       LOAD_VAL = 29'($urandom);
        default: LOAD_VAL = 29'h1FFF_FFFD;
      endcase
      SHIFT = 5'($urandom_range(31));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
